// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - operand-fetch / execute / write-back sequencer around the 8-bit ALU
// Optional flag outputs enabled by defining ALU_EXEC_FLAGS_EN.
module alu_exec_stage #(
    parameter int REG_COUNT  = 8,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    output logic [2:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_c,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  illegal,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  flag_z,
    output logic                  flag_n
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_W-1:0]       regs [REG_COUNT];
    logic [2:0]              op_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [REG_ADDR_W-1:0]   rs1_q;
    logic [REG_ADDR_W-1:0]   rs2_q;
    logic [DATA_W-1:0]       result_q;
    logic                    handshake;
    logic                    op_legal;
    logic                    op_unary;

    assign instr_ready = (state_q == IDLE);
    assign handshake   = instr_valid & instr_ready;
    assign dbg_data    = regs[dbg_addr];
    assign op_unary    = (op_q == OP_INC) || (op_q == OP_DEC);

    always_comb begin
        op_legal = 1'b0;
        case (instr_op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake && op_legal) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            alu_op   <= OP_ADD;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= handshake & ~op_legal;
            // Rejected ops leave the latched fields alone so alu_* keep their values.
            if (handshake && op_legal) begin
                op_q  <= instr_op;
                rd_q  <= instr_rd;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
            end
            case (state_q)
                READ: begin
                    alu_op <= op_q;
                    alu_a  <= regs[rs1_q];
                    alu_b  <= op_unary ? '0 : regs[rs2_q];
                end
                EXEC: begin
                    result_q <= alu_c;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= alu_c;
                end
                WB: begin
                    regs[rd_q] <= result_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state_q == WB) begin
            flag_z <= (result_q == '0);
            flag_n <= result_q[DATA_W-1];
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage
`timescale 1ns/1ps
module tb_alu_exec_stage;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] INC = 3'd2;
    localparam logic [2:0] DEC = 3'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'd0;
    logic [2:0] instr_rd = 3'd0;
    logic [2:0] instr_rs1 = 3'd0;
    logic [2:0] instr_rs2 = 3'd0;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_c;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       illegal;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;
    logic       flag_z;
    logic       flag_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [8];
    logic [2:0] m_op;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_z;
    logic       m_n;

    always #5 clk = ~clk;

    // Stand-in for the downstream combinational ALU.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ADD:     return 8'((int'(a) + int'(b)) % 256);
            SUB:     return 8'((int'(a) - int'(b) + 256) % 256);
            INC:     return 8'((int'(a) + 1) % 256);
            DEC:     return 8'((int'(a) + 255) % 256);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_c = alu_f(alu_op, alu_a, alu_b);

    alu_exec_stage dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flag_z(flag_z), .flag_n(flag_n)
    );

    function automatic logic exp_z();
`ifdef ALU_EXEC_FLAGS_EN
        return m_z;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_n();
`ifdef ALU_EXEC_FLAGS_EN
        return m_n;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_op = ADD; m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== m_regs[i]) begin
                errors++;
                $display("FAIL %s R%0d: got %h expected %h", tag, i, dbg_data, m_regs[i]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", tag, instr_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL %s wb_valid: got %b expected 0", tag, wb_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL %s illegal: got %b expected 0", tag, illegal); end
        checks++; if (alu_op !== ADD) begin errors++; $display("FAIL %s alu_op: got %h expected %h", tag, alu_op, ADD); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL %s alu_ab: got %h/%h expected 00/00", tag, alu_a, alu_b); end
        checks++; if (wb_rd !== 3'd0 || wb_data !== 8'h00) begin errors++; $display("FAIL %s wb_rd_data: got %0d/%h expected 0/00", tag, wb_rd, wb_data); end
        checks++; if (flag_z !== 1'b0 || flag_n !== 1'b0) begin errors++; $display("FAIL %s flags: got z%b n%b expected z0 n0", tag, flag_z, flag_n); end
    endtask

    // Caller must be at (or just after) a falling edge; returns just after the falling edge of the cycle where ready is high again.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        logic [7:0] a, b, r;
        logic legal;
        legal = (op <= DEC);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL pre_ready: got %b expected 1", instr_ready); end
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = 3'($urandom); instr_rd = 3'($urandom); instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
        if (!legal) begin
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse op%0d: got %b expected 1", op, illegal); end
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", instr_ready); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_wb: got %b expected 0", wb_valid); end
            checks++; if (alu_op !== m_op || alu_a !== m_a || alu_b !== m_b) begin errors++; $display("FAIL illegal_alu_hold: got %h/%h/%h expected %h/%h/%h", alu_op, alu_a, alu_b, m_op, m_a, m_b); end
            @(negedge clk);
            checks++; if (illegal !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_after: got ill%b wb%b expected 0/0", illegal, wb_valid); end
            checks++; if (flag_z !== exp_z() || flag_n !== exp_n()) begin errors++; $display("FAIL illegal_flags: got z%b n%b expected z%b n%b", flag_z, flag_n, exp_z(), exp_n()); end
            return;
        end
        a = m_regs[rs1];
        b = (op == INC || op == DEC) ? 8'h00 : m_regs[rs2];
        case (op)
            ADD:     r = 8'((int'(a) + int'(b)) % 256);
            SUB:     r = 8'((int'(a) - int'(b) + 256) % 256);
            INC:     r = 8'((int'(a) + 1) % 256);
            default: r = 8'((int'(a) + 255) % 256);
        endcase
        checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL t1: got rdy%b wb%b ill%b expected 0/0/0", instr_ready, wb_valid, illegal); end
        @(negedge clk);
        checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL t2: got rdy%b wb%b expected 0/0", instr_ready, wb_valid); end
        checks++; if (alu_op !== op || alu_a !== a || alu_b !== b) begin errors++; $display("FAIL alu_drive: got %h/%h/%h expected %h/%h/%h", alu_op, alu_a, alu_b, op, a, b); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_rd !== rd || wb_data !== r) begin errors++; $display("FAIL writeback: got v%b rd%0d %h expected v1 rd%0d %h", wb_valid, wb_rd, wb_data, rd, r); end
        checks++; if (instr_ready !== 1'b0 || alu_op !== op || alu_a !== a || alu_b !== b) begin errors++; $display("FAIL t3_hold: got rdy%b %h/%h/%h expected rdy0 %h/%h/%h", instr_ready, alu_op, alu_a, alu_b, op, a, b); end
        m_regs[rd] = r; m_op = op; m_a = a; m_b = b; m_z = (r == 8'h00); m_n = (r >= 8'h80);
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL t4: got rdy%b wb%b expected 1/0", instr_ready, wb_valid); end
        checks++; if (flag_z !== exp_z() || flag_n !== exp_n()) begin errors++; $display("FAIL flags: got z%b n%b expected z%b n%b", flag_z, flag_n, exp_z(), exp_n()); end
        dbg_addr = rd;
        #1;
        checks++; if (dbg_data !== r) begin errors++; $display("FAIL dbg_after_wb R%0d: got %h expected %h", rd, dbg_data, r); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs("reset");
        check_all_regs("reset");
        @(negedge clk);
    endtask

    task automatic test_add();
        for (int i = 0; i < 5; i++) run_instr(INC, 3'd1, 3'd1, 3'($urandom));
        for (int i = 0; i < 3; i++) run_instr(INC, 3'd2, 3'd2, 3'($urandom));
        run_instr(ADD, 3'd3, 3'd1, 3'd2);
        checks++; if (m_regs[3] !== 8'h08) begin errors++; $display("FAIL add_model: got %h expected 08", m_regs[3]); end
    endtask

    task automatic test_wrap();
        run_instr(DEC, 3'd4, 3'd4, 3'd7);
        run_instr(INC, 3'd4, 3'd4, 3'd7);
    endtask

    task automatic test_back_to_back();
        run_instr(SUB, 3'd5, 3'd2, 3'd1);
        run_instr(ADD, 3'd6, 3'd5, 3'd5);
        check_all_regs("b2b");
        @(negedge clk);
    endtask

    task automatic test_illegal();
        for (int i = 4; i < 8; i++) run_instr(3'(i), 3'($urandom), 3'($urandom), 3'($urandom));
        repeat (3) begin
            checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL illegal_quiet: got wb%b rdy%b expected 0/1", wb_valid, instr_ready); end
            @(negedge clk);
        end
        check_all_regs("illegal");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run_instr(op, 3'($urandom), 3'($urandom), 3'($urandom));
        end
        check_all_regs("random");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        instr_op = ADD; instr_rd = 3'd7; instr_rs1 = 3'd5; instr_rs2 = 3'd6; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs("reset_mid");
        repeat (3) begin
            @(negedge clk);
            checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_quiet: got wb%b rdy%b expected 0/1", wb_valid, instr_ready); end
        end
        check_all_regs("reset_mid");
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_wrap();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
